ascon_hash_seq: RTL and testbench

- Sequencer for the bit-serial Ascon hashing core.
- Accepts a parallel message over a valid/ready handshake and shifts it into the core one bit per cycle, together with per-cycle randomness and fault-mask bits.
- Pulses the core's start, waits for core ready, then deserialises the serial hash into a parallel word and offers it downstream.
- Sits between the host/bus wrapper and the hashing core; sole driver of the core's input pins.

---
 rtl/ascon_hash_seq_if.sv | 29 ++
 rtl/ascon_hash_seq.sv | 178 +++++++++++++++++
 tb/tb_ascon_hash_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_hash_seq_if.sv
// ascon_hash_seq_if: host-side message and hash handshake bundle for ascon_hash_seq.
// Latency: none; wires only.
// Backpressure: msg_valid_i/msg_ready_o and hash_valid_o/hash_ready_i valid-ready pairs.
interface ascon_hash_seq_if #(
   parameter int MSG_LEN  = 64,
   parameter int HASH_LEN = 256
);
   logic [MSG_LEN-1:0]  msg_i;
   logic                msg_valid_i;
   logic                msg_ready_o;
   logic [HASH_LEN-1:0] hash_o;
   logic                hash_valid_o;
   logic                hash_ready_i;
   logic                busy_o;
   logic [15:0]         cycles_o;
   logic                err_o;

   // host side: offers messages, accepts hashes
   modport master (
      output msg_i, msg_valid_i, hash_ready_i,
      input  msg_ready_o, hash_o, hash_valid_o, busy_o, cycles_o, err_o
   );

   // sequencer side
   modport slave (
      input  msg_i, msg_valid_i, hash_ready_i,
      output msg_ready_o, hash_o, hash_valid_o, busy_o, cycles_o, err_o
   );
endinterface

// File: rtl/ascon_hash_seq.sv
// ascon_hash_seq: serialises a message into the bit-serial Ascon core, runs it, deserialises the hash.
// Latency: accept to hash_valid_o = LOAD_LEN+START_CYC+W+1+DRAIN_DLY+HASH_LEN cycles (W = ready-low WAIT cycles).
// Backpressure: msg_ready_o only in IDLE (no queueing); hash held in DONE until hash_ready_i.
// Optional macro HASH_SEQ_TIMEOUT_EN bounds WAIT at TIMEOUT cycles and raises err_o.
module ascon_hash_seq #(
   parameter int          MSG_LEN   = 64,
   parameter int          HASH_LEN  = 256,
   parameter int          LOAD_LEN  = 256,
   parameter int          START_CYC = 5,
   parameter int          DRAIN_DLY = 4,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_5EED,
   parameter int          TIMEOUT   = 4096
) (
   input  logic            clk,
   input  logic            rst,
   ascon_hash_seq_if.slave bus,
   output logic [2:0]      core_mes_o,
   output logic [6:0]      core_r64_o,
   output logic            core_rfault_o,
   output logic            core_start_o,
   input  logic            core_hash_i,
   input  logic            core_ready_i
);

   localparam int MAX_A = (LOAD_LEN > HASH_LEN) ? LOAD_LEN : HASH_LEN;
   localparam int MAX_B = (START_CYC > DRAIN_DLY) ? START_CYC : DRAIN_DLY;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] LOAD_LAST  = CW'(LOAD_LEN - 1);
   localparam logic [CW-1:0] START_LAST = CW'(START_CYC - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'((DRAIN_DLY > 0) ? DRAIN_DLY - 1 : 0);
   localparam logic [CW-1:0] READ_LAST  = CW'(HASH_LEN - 1);

   // an all-zero seed would lock the LFSR up
   localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

   // the message shift register relies on LOAD covering every message bit
   if (LOAD_LEN < MSG_LEN || TIMEOUT < 1) begin : gBadParams
      $error("ascon_hash_seq: LOAD_LEN must be >= MSG_LEN and TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT, DRAIN, READ, DONE
   } stateT;

   stateT              state;
   logic [CW-1:0]      ctr;
   logic [MSG_LEN-1:0] msgSr;
   logic [31:0]        lfsr;
   logic [15:0]        latCnt;
`ifdef HASH_SEQ_TIMEOUT_EN
   logic [31:0]        waitCnt;
`endif

   // Galois step for x^32+x^22+x^2+x+1, shifting right
   function automatic logic [31:0] lfsrNext(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   assign bus.msg_ready_o = (state == IDLE);
   assign bus.busy_o      = (state != IDLE);

   // sequencer FSM with all core pins and host outputs registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         ctr              <= '0;
         msgSr            <= '0;
         lfsr             <= SEED;
         latCnt           <= '0;
         bus.hash_o       <= '0;
         bus.hash_valid_o <= 1'b0;
         bus.cycles_o     <= '0;
         bus.err_o        <= 1'b0;
         core_mes_o       <= '0;
         core_r64_o       <= '0;
         core_rfault_o    <= 1'b0;
         core_start_o     <= 1'b0;
`ifdef HASH_SEQ_TIMEOUT_EN
         waitCnt          <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.msg_valid_i) begin
                  // first LOAD cycle already presents bit MSG_LEN-1
                  msgSr          <= bus.msg_i << 1;
                  core_mes_o[0]  <= bus.msg_i[MSG_LEN-1];
                  {core_rfault_o, core_r64_o, core_mes_o[2:1]} <= lfsr[9:0];
                  lfsr           <= lfsrNext(lfsr);
                  ctr            <= '0;
                  state          <= LOAD;
`ifdef HASH_SEQ_TIMEOUT_EN
                  bus.err_o      <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (ctr == LOAD_LAST) begin
                  // core pins keep the last LOAD values through START
                  core_start_o <= 1'b1;
                  latCnt       <= '0;
                  ctr          <= '0;
                  state        <= START;
               end else begin
                  // zeros shifted into msgSr provide the padding past MSG_LEN
                  core_mes_o[0] <= msgSr[MSG_LEN-1];
                  msgSr         <= msgSr << 1;
                  {core_rfault_o, core_r64_o, core_mes_o[2:1]} <= lfsr[9:0];
                  lfsr          <= lfsrNext(lfsr);
                  ctr           <= ctr + 1'b1;
               end
            end
            START: begin
               latCnt <= latCnt + 16'd1;
               if (ctr == START_LAST) begin
                  core_start_o  <= 1'b0;
                  core_mes_o    <= '0;
                  core_r64_o    <= '0;
                  core_rfault_o <= 1'b0;
                  ctr           <= '0;
                  state         <= WAIT;
`ifdef HASH_SEQ_TIMEOUT_EN
                  waitCnt       <= '0;
`endif
               end else begin
                  ctr <= ctr + 1'b1;
               end
            end
            WAIT: begin
               if (core_ready_i) begin
                  bus.cycles_o <= latCnt;
                  ctr          <= '0;
                  state        <= (DRAIN_DLY == 0) ? READ : DRAIN;
               end else begin
                  latCnt <= (latCnt == 16'hFFFF) ? latCnt : latCnt + 16'd1;
`ifdef HASH_SEQ_TIMEOUT_EN
                  if (waitCnt == 32'(TIMEOUT - 1)) begin
                     bus.err_o        <= 1'b1;
                     bus.hash_o       <= '0;
                     bus.hash_valid_o <= 1'b1;
                     state            <= DONE;
                  end else begin
                     waitCnt <= waitCnt + 32'd1;
                  end
`endif
               end
            end
            DRAIN: begin
               ctr <= ctr + 1'b1;
               if (ctr == DRAIN_LAST) begin
                  ctr   <= '0;
                  state <= READ;
               end
            end
            READ: begin
               // shifting in from the top leaves the first captured bit at hash_o[0]
               bus.hash_o <= {core_hash_i, bus.hash_o[HASH_LEN-1:1]};
               ctr        <= ctr + 1'b1;
               if (ctr == READ_LAST) begin
                  ctr              <= '0;
                  bus.hash_valid_o <= 1'b1;
                  state            <= DONE;
               end
            end
            DONE: begin
               if (bus.hash_ready_i) begin
                  bus.hash_valid_o <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_hash_seq.sv
// tb_ascon_hash_seq: directed bench with a core model and a hash scoreboard for ascon_hash_seq.
// Latency: checks accept-to-hash_valid cycle counts against the closed-form run length.
// Backpressure: exercises held msg_valid_i, early hash_ready_i and DONE handshakes.
module tb_ascon_hash_seq;

   localparam int          MSG_LEN   = 64;
   localparam int          HASH_LEN  = 256;
   localparam int          LOAD_LEN  = 256;
   localparam int          START_CYC = 5;
   localparam int          DRAIN_DLY = 4;
   localparam logic [31:0] SEED      = 32'hACE1_5EED;
   localparam int          TB_TOUT   = 64;

   typedef struct {
      logic [HASH_LEN-1:0] hash;
      logic [15:0]         cycles;
      logic                err;
   } expT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [2:0] core_mes_o;
   logic [6:0] core_r64_o;
   logic       core_rfault_o;
   logic       core_start_o;
   logic       core_hash_i;
   logic       core_ready_i;

   ascon_hash_seq_if #(.MSG_LEN(MSG_LEN), .HASH_LEN(HASH_LEN)) bus ();

   ascon_hash_seq #(
      .MSG_LEN(MSG_LEN), .HASH_LEN(HASH_LEN), .LOAD_LEN(LOAD_LEN),
      .START_CYC(START_CYC), .DRAIN_DLY(DRAIN_DLY), .LFSR_SEED(SEED), .TIMEOUT(TB_TOUT)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .core_mes_o(core_mes_o), .core_r64_o(core_r64_o), .core_rfault_o(core_rfault_o),
      .core_start_o(core_start_o), .core_hash_i(core_hash_i), .core_ready_i(core_ready_i)
   );

   always #5 clk = ~clk;

   int cycCnt = 0;
   always @(posedge clk) cycCnt <= cycCnt + 1;

   int                  nAsserts = 0;
   int                  nFail    = 0;
   expT                 sbq[$];
   logic [31:0]         modelLfsr = SEED;
   logic [9:0]          lastRand;
   logic                lastMes0;
   logic [15:0]         lastCycles = 16'h0;
   int                  acceptCyc;
   int                  readyDly = 0;
   bit                  earlyReady = 1'b0;
   bit                  neverReady = 1'b0;
   logic [HASH_LEN-1:0] corePat = '0;

   function automatic logic [31:0] lfsrNext(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // core model: ready after readyDly WAIT cycles (or during START), then corePat bit 0 first
   initial begin : coreModel
      core_ready_i = 1'b0;
      core_hash_i  = 1'b0;
      forever begin
         @(negedge clk);
         if (core_start_o && !neverReady) begin
            if (earlyReady) core_ready_i = 1'b1;
            while (core_start_o) @(negedge clk);
            if (!earlyReady) repeat (readyDly) @(negedge clk);
            core_ready_i = 1'b1;
            @(negedge clk);
            core_ready_i = 1'b0;
            for (int c = 1; c <= DRAIN_DLY + HASH_LEN; c++) begin
               core_hash_i = (c > DRAIN_DLY) ? corePat[c - DRAIN_DLY - 1] : 1'b0;
               if (c < DRAIN_DLY + HASH_LEN) @(negedge clk);
            end
            @(negedge clk);
            core_hash_i = 1'b0;
         end
      end
   end

   // called at a negedge; returns at the negedge of the first LOAD cycle
   task automatic acceptMsg(input logic [63:0] m, input bit hold, output int waited);
      bus.msg_i       = m;
      bus.msg_valid_i = 1'b1;
      waited = 0;
      while (!bus.msg_ready_o && waited < 20000) begin
         @(negedge clk);
         waited++;
      end
      check("accept_rdy", bus.msg_ready_o, 1);
      @(negedge clk);
      acceptCyc = cycCnt;
      if (!hold) bus.msg_valid_i = 1'b0;
   endtask

   task automatic checkLoad(input logic [63:0] m, input int abortAt);
      logic [9:0] expRand;
      logic       expMes0;
      for (int k = 0; k < LOAD_LEN; k++) begin
         expRand   = modelLfsr[9:0];
         modelLfsr = lfsrNext(modelLfsr);
         expMes0   = (k < MSG_LEN) ? m[MSG_LEN-1-k] : 1'b0;
         if (k == abortAt) begin
            rst = 1'b0;
            #1;
            check("rst_core", {core_start_o, core_mes_o, core_r64_o, core_rfault_o}, 0);
            check("rst_flags", {bus.hash_valid_o, bus.busy_o, bus.err_o}, 0);
            check("rst_ready", bus.msg_ready_o, 1);
            check("rst_cycles", bus.cycles_o, 0);
            check("rst_hash", bus.hash_o, 0);
            void'(sbq.pop_back());
            modelLfsr  = SEED;
            lastCycles = 16'h0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            return;
         end
         check("load_mes0", core_mes_o[0], expMes0);
         check("load_rand", {core_rfault_o, core_r64_o, core_mes_o[2:1]}, expRand);
         if (k == 0) check("load_busy", {bus.busy_o, bus.msg_ready_o, core_start_o}, 3'b100);
         lastMes0 = expMes0;
         lastRand = expRand;
         @(negedge clk);
      end
   endtask

   task automatic checkStart();
      for (int s = 0; s < START_CYC; s++) begin
         check("start_hi", core_start_o, 1);
         check("start_hold", {core_rfault_o, core_r64_o, core_mes_o}, {lastRand, lastMes0});
         @(negedge clk);
      end
      check("start_lo", core_start_o, 0);
   endtask

   task automatic finishRun(input int expLat);
      int  guard;
      expT e;
      guard = 0;
      while (!bus.hash_valid_o && guard < 20000) begin
         @(negedge clk);
         guard++;
      end
      check("valid_seen", bus.hash_valid_o, 1);
      check("latency", cycCnt - acceptCyc, expLat);
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         check("hash", bus.hash_o, e.hash);
         check("cycles", bus.cycles_o, e.cycles);
         check("err", bus.err_o, e.err);
         lastCycles = e.cycles;
         repeat (2) @(negedge clk);
         check("done_valid_hold", bus.hash_valid_o, 1);
         check("done_hash_hold", bus.hash_o, e.hash);
      end
      bus.hash_ready_i = 1'b1;
      @(negedge clk);
      bus.hash_ready_i = 1'b0;
      check("done_exit", {bus.hash_valid_o, bus.msg_ready_o}, 2'b01);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int                  w;
      logic [63:0]         m;
      logic [HASH_LEN-1:0] pat;
      bus.msg_i        = '0;
      bus.msg_valid_i  = 1'b0;
      bus.hash_ready_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("reset_core", {core_start_o, core_mes_o, core_r64_o, core_rfault_o}, 0);
      check("reset_flags", {bus.hash_valid_o, bus.busy_o, bus.err_o, bus.msg_ready_o}, 4'b0001);
      check("reset_cycles", bus.cycles_o, 0);
      check("reset_hash", bus.hash_o, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // run 1: ready after 40 WAIT cycles, hash 1,0,1,1; early hash_ready_i ignored
      m = 64'h0123_4567_89AB_CDEF;
      corePat = 256'hD; readyDly = 40;
      acceptMsg(m, 1'b0, w);
      sbq.push_back('{hash: corePat, cycles: 16'(START_CYC + 40), err: 1'b0});
      bus.hash_ready_i = 1'b1;
      checkLoad(m, -1);
      bus.hash_ready_i = 1'b0;
      checkStart();
      finishRun(LOAD_LEN + START_CYC + 40 + 1 + DRAIN_DLY + HASH_LEN);

      // runs 2-3: msg_valid_i held; second accept right after the DONE handshake
      m = 64'hFEDC_BA98_7654_3210;
      pat = {8{32'hC3A5_0F96}};
      corePat = pat; readyDly = 7;
      acceptMsg(m, 1'b1, w);
      bus.msg_i = ~m;
      sbq.push_back('{hash: pat, cycles: 16'(START_CYC + 7), err: 1'b0});
      checkLoad(m, -1);
      checkStart();
      finishRun(LOAD_LEN + START_CYC + 7 + 1 + DRAIN_DLY + HASH_LEN);
      m = 64'h8000_0000_0000_0001;
      pat = {4{64'h1357_9BDF_2468_ACE0}};
      corePat = pat; readyDly = 2;
      acceptMsg(m, 1'b1, w);
      check("second_accept_imm", w, 0);
      sbq.push_back('{hash: pat, cycles: 16'(START_CYC + 2), err: 1'b0});
      checkLoad(m, -1);
      checkStart();
      finishRun(LOAD_LEN + START_CYC + 2 + 1 + DRAIN_DLY + HASH_LEN);
      bus.msg_valid_i = 1'b0;

      // reset mid-LOAD at ctr 100
      m = 64'hA5A5_5A5A_F00D_CAFE;
      acceptMsg(m, 1'b0, w);
      sbq.push_back('{hash: '0, cycles: 16'h0, err: 1'b0});
      checkLoad(m, 100);

      // rerun from seed, with core ready raised during START
      pat = {16{16'h6B1D}};
      corePat = pat; earlyReady = 1'b1;
      acceptMsg(m, 1'b0, w);
      sbq.push_back('{hash: pat, cycles: 16'(START_CYC), err: 1'b0});
      checkLoad(m, -1);
      checkStart();
      finishRun(LOAD_LEN + START_CYC + 0 + 1 + DRAIN_DLY + HASH_LEN);
      earlyReady = 1'b0;

      // core never ready
      neverReady = 1'b1;
`ifdef HASH_SEQ_TIMEOUT_EN
      acceptMsg(64'h1111_2222_3333_4444, 1'b0, w);
      sbq.push_back('{hash: '0, cycles: lastCycles, err: 1'b1});
      finishRun(LOAD_LEN + START_CYC + TB_TOUT);
      acceptMsg(64'h5555_6666_7777_8888, 1'b0, w);
      check("err_cleared", bus.err_o, 0);
`else
      acceptMsg(64'h1111_2222_3333_4444, 1'b0, w);
      repeat (LOAD_LEN + START_CYC + 1000) @(negedge clk);
      check("wait_forever", {bus.busy_o, bus.hash_valid_o, bus.err_o}, 3'b100);
`endif
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
